// File: rtl/csp_tree_pkg.sv
// Shared definitions for the CSP tree injector: packet layout, leaf ids,
// sender state encoding and the routing-field function.
package csp_tree_pkg;

    localparam int unsigned WIDTH     = 11;
    localparam int unsigned NSRC      = 8;
    localparam int unsigned ROUTE_MSB = 10;
    localparam int unsigned SRC_LSB   = 3;
    localparam int unsigned DST_LSB   = 0;
    localparam int unsigned ID_W      = 3;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned COUNT_W   = 6;
    localparam int unsigned MAX_SENT  = NSRC * (NSRC - 1);

    localparam logic [ID_W-1:0] LEAF_A = 3'd0;
    localparam logic [ID_W-1:0] LEAF_B = 3'd1;
    localparam logic [ID_W-1:0] LEAF_C = 3'd2;
    localparam logic [ID_W-1:0] LEAF_D = 3'd3;
    localparam logic [ID_W-1:0] LEAF_E = 3'd4;
    localparam logic [ID_W-1:0] LEAF_F = 3'd5;
    localparam logic [ID_W-1:0] LEAF_G = 3'd6;
    localparam logic [ID_W-1:0] LEAF_H = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_REQ   = 3'd2,
        S_RTZ   = 3'd3,
        S_GAPW  = 3'd4,
        S_DONE  = 3'd5
    } sender_state_t;

    typedef struct packed {
        logic [4:0]      route;
        logic [ID_W-1:0] src;
        logic [ID_W-1:0] dst;
    } packet_t;

    // Highest differing id bit picks the tree level where the packet turns down.
    function automatic logic [4:0] route_of(input logic [ID_W-1:0] src,
                                            input logic [ID_W-1:0] dst);
        logic [ID_W-1:0] x;
        x = src ^ dst;
        if (x[2])      return {3'b001, dst[1:0]};
        else if (x[1]) return {2'b01, dst[0], 2'b00};
        else           return 5'b10000;
    endfunction

    function automatic packet_t packet_of(input logic [ID_W-1:0] src,
                                          input logic [ID_W-1:0] dst);
        packet_t p;
        p.route = route_of(src, dst);
        p.src   = src;
        p.dst   = dst;
        return p;
    endfunction

endpackage

// File: rtl/csp_chan_sender.sv
// One leaf channel: ack synchroniser, 4-phase handshake FSM walking all
// destinations except itself, gap and timeout counters, data register.
module csp_chan_sender
    import csp_tree_pkg::*;
#(
    parameter logic [ID_W-1:0] SRC     = 3'd0,
    parameter int unsigned     GAP     = 2,
    parameter int unsigned     TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_go,
    input  logic             enable,
    input  logic             run_end,
    input  logic             ack,
    output logic             req,
    output logic [WIDTH-1:0] data,
    output logic             leave_req_c,
    output logic             timeout_c,
    output logic             done_c
);

    localparam logic [ID_W-1:0] FIRST_DST = (SRC == LEAF_A) ? LEAF_B : LEAF_A;
    localparam logic [ID_W-1:0] LAST_DST  = (SRC == LEAF_H) ? LEAF_G : LEAF_H;

    sender_state_t    state, state_d;
    logic [ID_W-1:0]  dst, dst_d, dst_next;
    logic [CNT_W-1:0] gap_cnt, gap_d;
    logic [CNT_W-1:0] tcnt, tcnt_d;
    packet_t          pkt_q, pkt_d;
    logic             ack_s1, ack_s;
    logic             advance;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            dst     <= '0;
            gap_cnt <= '0;
            tcnt    <= '0;
            pkt_q   <= '0;
            req     <= 1'b0;
            ack_s1  <= 1'b0;
            ack_s   <= 1'b0;
        end else begin
            state   <= state_d;
            dst     <= dst_d;
            gap_cnt <= gap_d;
            tcnt    <= tcnt_d;
            pkt_q   <= pkt_d;
            req     <= (state_d == S_REQ);
            ack_s1  <= ack;
            ack_s   <= ack_s1;
        end
    end

    always_comb begin
        state_d     = state;
        dst_d       = dst;
        gap_d       = gap_cnt;
        pkt_d       = pkt_q;
        tcnt_d      = tcnt;
        leave_req_c = 1'b0;
        timeout_c   = 1'b0;
        advance     = 1'b0;

        dst_next = dst + 3'd1;
        if (dst_next == SRC) dst_next = dst_next + 3'd1;

        unique case (state)
            S_IDLE: begin
                pkt_d = '0;
                if (start_go) begin
                    if (enable) begin
                        state_d = S_SETUP;
                        dst_d   = FIRST_DST;
                        pkt_d   = packet_of(SRC, FIRST_DST);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SETUP: state_d = S_REQ;
            S_REQ: begin
                if (ack_s) begin
                    state_d     = S_RTZ;
                    leave_req_c = 1'b1;
                end
            end
            S_RTZ: begin
                if (!ack_s) begin
                    if (GAP > 0) begin
                        state_d = S_GAPW;
                        gap_d   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_GAPW: begin
                if (gap_cnt == CNT_W'(GAP - 1)) advance = 1'b1;
                else                            gap_d   = gap_cnt + 8'd1;
            end
            S_DONE: begin
                pkt_d = '0;
                if (run_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Next packet or finish; data is loaded on entry to SETUP and held.
        if (advance) begin
            if (dst == LAST_DST) begin
                state_d = S_DONE;
                pkt_d   = '0;
            end else begin
                state_d = S_SETUP;
                dst_d   = dst_next;
                pkt_d   = packet_of(SRC, dst_next);
            end
        end

        if (state_d != state)  tcnt_d = '0;
        else if (tcnt != '1)   tcnt_d = tcnt + 8'd1;

        timeout_c = ((state == S_REQ) || (state == S_RTZ)) && (state_d == state)
                    && (tcnt_d == CNT_W'(TIMEOUT));
    end

    assign data   = pkt_q;
    assign done_c = (state == S_DONE);

endmodule

// File: rtl/csp_tree_injector.sv
// All-to-all traffic scheduler for the 8 leaf channels of the CSP tree:
// start/done control, sticky timeout and handshake counting.
module csp_tree_injector
    import csp_tree_pkg::*;
#(
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NSRC-1:0]       src_mask,
    input  logic [NSRC-1:0]       ack,
    output logic [NSRC-1:0]       req,
    output logic [NSRC*WIDTH-1:0] data,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [COUNT_W-1:0]    sent_count
);

    logic [NSRC-1:0]    leave_c, to_c, done_vec_c;
    logic               all_done_c, start_acc_c;
    logic [3:0]         pop_c;
    logic [COUNT_W:0]   sum_c;
    logic [COUNT_W-1:0] sent_next_c;

    // A start landing while senders wait in DONE would be lost, so hold it off.
    assign all_done_c  = &done_vec_c;
    assign start_acc_c = start & ~busy & ~all_done_c;

    for (genvar g = 0; g < NSRC; g++) begin : g_chan
        csp_chan_sender #(
            .SRC     (3'(g)),
            .GAP     (GAP),
            .TIMEOUT (TIMEOUT)
        ) u_sender (
            .clk         (clk),
            .reset       (reset),
            .start_go    (start_acc_c),
            .enable      (src_mask[g]),
            .run_end     (all_done_c),
            .ack         (ack[g]),
            .req         (req[g]),
            .data        (data[g*WIDTH +: WIDTH]),
            .leave_req_c (leave_c[g]),
            .timeout_c   (to_c[g]),
            .done_c      (done_vec_c[g])
        );
    end

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < NSRC; i++) pop_c = pop_c + 4'(leave_c[i]);
        sum_c       = 7'(sent_count) + 7'(pop_c);
        sent_next_c = (sum_c > 7'(MAX_SENT)) ? COUNT_W'(MAX_SENT) : COUNT_W'(sum_c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            sent_count <= '0;
        end else if (start_acc_c) begin
            busy       <= |src_mask;
            done       <= ~|src_mask;
            timeout    <= 1'b0;
            sent_count <= '0;
        end else begin
            if (all_done_c) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (|to_c) timeout <= 1'b1;
            sent_count <= sent_next_c;
        end
    end

endmodule

// File: tb/tb_csp_tree_injector.sv
// Self-checking bench: per-channel scoreboard of expected packets, instant-ack
// sink with a stuck-ack option, and run-level control/status checks.
module tb_csp_tree_injector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_mask = 8'h00;
    logic [7:0]  ack = 8'h00;
    logic [7:0]  req;
    logic [87:0] data;
    logic        busy, done, timeout;
    logic [5:0]  sent_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [7:0]  stuck = 8'h00;
    logic [7:0]  req_prev = 8'h00;
    logic [10:0] mon_w;

    logic [10:0] exp_q [8][$];
    logic [10:0] seen [8][8];
    logic [10:0] first_word [8];
    bit          first_ok [8];
    int          rises [8];
    int          pushed [8];

    csp_tree_injector #(.GAP(2), .TIMEOUT(255)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_mask   (src_mask),
        .ack        (ack),
        .req        (req),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [87:0] got, input logic [87:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference packet built from tree geometry: which id bit first differs.
    function automatic logic [10:0] model_pkt(input int s, input int d);
        logic [2:0] sv;
        logic [2:0] dv;
        logic [4:0] r;
        sv = 3'(s);
        dv = 3'(d);
        if (sv[2] != dv[2])      r = {3'b001, dv[1:0]};
        else if (sv[1] != dv[1]) r = {2'b01, dv[0], 2'b00};
        else                     r = 5'b10000;
        return {r, sv, dv};
    endfunction

    // Sink and monitor: ack mirrors req half a cycle later; each new req is checked.
    always @(negedge clk) begin
        if (!reset) begin
            req_prev = 8'h00;
            ack      = 8'h00;
        end else begin
            for (int c = 0; c < 8; c++) begin
                if (req[c] && !req_prev[c]) begin
                    mon_w = data[c*11 +: 11];
                    rises[c]++;
                    seen[c][mon_w[2:0]] = mon_w;
                    if (!first_ok[c]) begin
                        first_word[c] = mon_w;
                        first_ok[c]   = 1'b1;
                    end
                    if (exp_q[c].size() > 0)
                        chk($sformatf("pkt_ch%0d", c), 88'(mon_w), 88'(exp_q[c].pop_front()));
                end
            end
            req_prev = req;
            ack      = req & ~stuck;
        end
    end

    task automatic clear_sb();
        for (int c = 0; c < 8; c++) begin
            exp_q[c].delete();
            rises[c]    = 0;
            pushed[c]   = 0;
            first_ok[c] = 1'b0;
            for (int d = 0; d < 8; d++) seen[c][d] = '0;
        end
    endtask

    task automatic do_start(input logic [7:0] m);
        clear_sb();
        for (int s = 0; s < 8; s++)
            if (m[s])
                for (int d = 0; d < 8; d++)
                    if (d != s) begin
                        exp_q[s].push_back(model_pkt(s, d));
                        pushed[s]++;
                    end
        @(negedge clk);
        start    = 1'b1;
        src_mask = m;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (!(done && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 88'(done && !busy), 88'd1);
    endtask

    task automatic run_end_checks(input logic [7:0] m);
        chk("sent_count", 88'(sent_count), 88'(7 * $countones(m)));
        for (int c = 0; c < 8; c++)
            chk($sformatf("pkts_ch%0d", c), 88'(rises[c]), 88'(pushed[c]));
    endtask

    initial begin
        int n;
        int unsigned t0;
        logic [5:0] cnt_snap;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", 88'(req), 88'd0);
        chk("rst_data", data, 88'd0);
        chk("rst_flags", 88'({busy, done, timeout}), 88'd0);
        chk("rst_cnt", 88'(sent_count), 88'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 88'(busy), 88'd0);

        // Full all-to-all run, with an ignored start mid-run
        do_start(8'hFF);
        chk("busy_set", 88'(busy), 88'd1);
        n = 0;
        while (sent_count < 6'd10 && n < 500) begin @(negedge clk); n++; end
        cnt_snap = sent_count;
        start = 1'b1; src_mask = 8'h00;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 88'(busy), 88'd1);
        chk("ign_cnt_kept", 88'(sent_count >= cnt_snap && cnt_snap != 0), 88'd1);
        wait_idle(3000, "ff_idle");
        run_end_checks(8'hFF);
        chk("ff_timeout", 88'(timeout), 88'd0);
        chk("c0_first", 88'(first_word[0]), 88'(11'b10000_000_001));
        chk("c0_last", 88'(seen[0][7]), 88'(11'b00111_000_111));
        chk("c4_to_b", 88'(seen[4][1]), 88'(11'b00101_100_001));
        chk("c6_to_h", 88'(seen[6][7]), 88'(11'b10000_110_111));

        // Single source C
        do_start(8'b0000_0100);
        wait_idle(3000, "c_idle");
        run_end_checks(8'b0000_0100);
        chk("c2_first", 88'(first_word[2]), 88'(11'b01000_010_000));
        chk("c2_last", 88'(seen[2][7]), 88'(11'b00111_010_111));

        // ack[3] stuck low: timeout latency, others finish, run never ends
        stuck = 8'h08;
        do_start(8'hFF);
        n = 0;
        while (!req[3] && n < 50) begin @(negedge clk); n++; end
        chk("req3_seen", 88'(req[3]), 88'd1);
        t0 = cyc;
        n = 0;
        while (!timeout && n < 400) begin @(negedge clk); n++; end
        chk("timeout_lat", 88'(cyc - t0), 88'd255);
        n = 0;
        while (sent_count != 6'd49 && n < 3000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        chk("stuck_cnt", 88'(sent_count), 88'd49);
        chk("stuck_done", 88'(done), 88'd0);
        chk("stuck_req3", 88'({busy, req[3], timeout}), 88'd7);

        // Reset mid-handshake drops req immediately
        stuck = 8'h00;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        do_start(8'hFF);
        n = 0;
        while (req != 8'hFF && n < 50) begin @(negedge clk); n++; end
        chk("req_all", 88'(req), 88'hFF);
        #2 reset = 1'b0;
        #1;
        chk("async_req", 88'(req), 88'd0);
        chk("async_data", data, 88'd0);
        chk("async_busy", 88'(busy), 88'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Empty mask completes at once
        chk("pre_m0_done", 88'(done), 88'd0);
        do_start(8'h00);
        chk("m0_done_busy", 88'({done, busy}), 88'b10);
        repeat (3) @(negedge clk);

        // Fresh run after reset starts from the first destination
        do_start(8'hFF);
        chk("restart_cnt", 88'(sent_count), 88'd0);
        wait_idle(3000, "re_idle");
        run_end_checks(8'hFF);
        chk("re_c0_first", 88'(first_word[0]), 88'(11'b10000_000_001));
        chk("re_c1_first", 88'(first_word[1]), 88'(11'b10000_001_000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
